// File: rtl/vx_sched_pkg.sv
// Shared types and width helpers for the weighted round-robin stream scheduler.
package vx_sched_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int PERF_CNTW = 32;

  // Index width of a requester vector; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_sched_skid_buf.sv
// Two-entry skid buffer; in_ready depends only on registered occupancy, never on out_ready.
module vx_sched_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/vx_wrr_stream_sched.sv
// Packet-aware weighted round-robin scheduler sharing one output stream.
// Optional perf counters enabled by defining VX_WRR_SCHED_PERF_EN.
module vx_wrr_stream_sched
  import vx_sched_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 8,
  parameter int WEIGHTW  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             valid_in,
  input  logic [NUM_REQS*DATAW-1:0]       data_in,
  input  logic [NUM_REQS-1:0]             last_in,
  input  logic [NUM_REQS*WEIGHTW-1:0]     weights_in,
  output logic [NUM_REQS-1:0]             ready_in,
  output logic                            valid_out,
  output logic [DATAW-1:0]                data_out,
  output logic                            last_out,
  output logic [idx_width(NUM_REQS)-1:0]  sel_index_out,
  input  logic                            ready_out
`ifdef VX_WRR_SCHED_PERF_EN
  ,
  output logic [PERF_CNTW-1:0]            perf_stall_cycles,
  output logic [PERF_CNTW-1:0]            perf_packets
`endif
);

  localparam int IDXW = idx_width(NUM_REQS);
  localparam int BUFW = IDXW + 1 + DATAW;

  state_e             state, state_n;
  logic [IDXW-1:0]    cur_ptr, cur_ptr_n, sel;
  logic [WEIGHTW-1:0] credit, credit_n, sel_weight, eff_weight;
  logic [NUM_REQS-1:0] grant;
  logic               any_grant, reload, accept, sel_last, buf_ready;
  logic [DATAW-1:0]   sel_data;
  logic [BUFW-1:0]    buf_out;
  int                 j;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cur_ptr <= '0;
      credit  <= '0;
    end else begin
      state   <= state_n;
      cur_ptr <= cur_ptr_n;
      credit  <= credit_n;
    end
  end

  always_comb begin
    state_n   = state;
    cur_ptr_n = cur_ptr;
    credit_n  = credit;
    sel       = cur_ptr;
    any_grant = 1'b0;
    reload    = 1'b0;
    j         = 0;

    if (state == LOCKED) begin
      any_grant = valid_in[cur_ptr];
    end else if (valid_in[cur_ptr] && (credit != '0)) begin
      any_grant = 1'b1;
    end else begin
      // Walk the wrap backwards so the nearest requester after cur_ptr is the last to win.
      for (int k = NUM_REQS; k >= 1; k--) begin
        j = int'(cur_ptr) + k;
        if (j >= NUM_REQS) j = j - NUM_REQS;
        if (valid_in[IDXW'(j)]) begin
          sel       = IDXW'(j);
          any_grant = 1'b1;
          reload    = 1'b1;
        end
      end
    end

    sel_weight = weights_in[sel*WEIGHTW +: WEIGHTW];
    eff_weight = (sel_weight == '0) ? WEIGHTW'(1) : sel_weight;
    sel_data   = data_in[sel*DATAW +: DATAW];
    sel_last   = last_in[sel];
    grant      = any_grant ? (NUM_REQS'(1) << sel) : '0;
    ready_in   = grant & {NUM_REQS{buf_ready && !reset}};
    accept     = any_grant && buf_ready && !reset;

    if (accept) begin
      state_n = sel_last ? IDLE : LOCKED;
      if (reload) begin
        cur_ptr_n = sel;
        credit_n  = sel_last ? (eff_weight - WEIGHTW'(1)) : eff_weight;
      end else if (sel_last && (credit != '0)) begin
        credit_n = credit - WEIGHTW'(1);
      end
    end
  end

  vx_sched_skid_buf #(
    .W (BUFW)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept),
    .in_data   ({sel, sel_last, sel_data}),
    .in_ready  (buf_ready),
    .out_valid (valid_out),
    .out_data  (buf_out),
    .out_ready (ready_out)
  );

  assign {sel_index_out, last_out, data_out} = buf_out;

`ifdef VX_WRR_SCHED_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_packets      <= '0;
    end else begin
      if (valid_out && !ready_out) perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (valid_out && ready_out && last_out) perf_packets <= perf_packets + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_wrr_stream_sched.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_vx_wrr_stream_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int WW = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    valid_in, last_in, ready_in;
  logic [N*DW-1:0] data_in;
  logic [N*WW-1:0] weights_in;
  logic            valid_out, last_out, ready_out;
  logic [DW-1:0]   data_out;
  logic [IW-1:0]   sel_index_out;
`ifdef VX_WRR_SCHED_PERF_EN
  logic [31:0]     perf_stall_cycles, perf_packets;
`endif

  vx_wrr_stream_sched #(.NUM_REQS(N), .DATAW(DW), .WEIGHTW(WW)) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .last_in       (last_in),
    .weights_in    (weights_in),
    .ready_in      (ready_in),
    .valid_out     (valid_out),
    .data_out      (data_out),
    .last_out      (last_out),
    .sel_index_out (sel_index_out),
    .ready_out     (ready_out)
`ifdef VX_WRR_SCHED_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_packets      (perf_packets)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int data;
    bit last;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  int    dut_acc = 0;
  int    m_cur, m_credit;
  bit    m_locked;
  beat_t q[$];
  int    out_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_w(input int i);
    int w;
    w = int'(weights_in[i*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  // Winner under the packet-lock / credit / cyclic-search rules; -1 means nobody.
  function automatic int model_grant(output bit reload);
    reload = 1'b0;
    if (m_locked) return valid_in[m_cur] ? m_cur : -1;
    if (valid_in[m_cur] && m_credit > 0) return m_cur;
    for (int k = 1; k <= N; k++) begin
      int jj;
      jj = (m_cur + k) % N;
      if (valid_in[jj]) begin
        reload = 1'b1;
        return jj;
      end
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_cur = 0;
    m_credit = 0;
    m_locked = 1'b0;
    q.delete();
    out_log.delete();
  endtask

  task automatic cycle();
    int g;
    bit rl;
    logic [N-1:0] er;
    beat_t b;
    #1;
    g = model_grant(rl);
    er = '0;
    if (g >= 0 && q.size() < 2) er[g] = 1'b1;
    chk("ready_in", 32'(ready_in), 32'(er));
    chk("valid_out", 32'(valid_out), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("data_out", 32'(data_out), 32'(q[0].data));
      chk("last_out", 32'(last_out), 32'(q[0].last));
      chk("sel_index_out", 32'(sel_index_out), 32'(q[0].idx));
      if (ready_out) begin
        b = q.pop_front();
        out_log.push_back(b.idx);
      end
    end
    if (|(valid_in & ready_in)) dut_acc++;
    if (er != '0) begin
      b.idx  = g;
      b.data = int'(data_in[g*DW +: DW]);
      b.last = last_in[g];
      q.push_back(b);
      if (rl) begin
        m_cur    = g;
        m_credit = eff_w(g);
      end
      if (b.last) m_credit = (m_credit > 0) ? m_credit - 1 : 0;
      m_locked = !b.last;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    valid_in  = '0;
    last_in   = '0;
    data_in   = '0;
    ready_out = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_last_out", 32'(last_out), 32'd0);
    chk("rst_sel_index", 32'(sel_index_out), 32'd0);
    chk("rst_ready_in", 32'(ready_in), 32'd0);
    model_clear();
    reset = 1'b0;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic ro);
    valid_in  = v;
    last_in   = l;
    ready_out = ro;
    data_in   = $urandom;
  endtask

  int exp1[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  int exp2[8] = '{1, 0, 0, 0, 1, 0, 0, 0};
  int acc0;

  initial begin
    weights_in = {4'h1, 4'h1, 4'h1, 4'h1};
    do_reset();

    // Equal weights, all valid, single-beat packets.
    for (int c = 0; c < 9; c++) begin
      drive(4'b1111, 4'b1111, 1'b1);
      cycle();
    end
    chk("t1_len", 32'(out_log.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      if (k < out_log.size()) chk("t1_seq", 32'(out_log[k]), 32'(exp1[k]));

    // r0 weight 3, r1 weight 1.
    weights_in = {4'h1, 4'h1, 4'h1, 4'h3};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      drive(4'b0011, 4'b1111, 1'b1);
      cycle();
    end
    chk("t2_len", 32'(out_log.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      if (k < out_log.size()) chk("t2_seq", 32'(out_log[k]), 32'(exp2[k]));

    // Four-beat packet from r2 holds off r1.
    weights_in = {4'h1, 4'h1, 4'h1, 4'h1};
    do_reset();
    drive(4'b0100, 4'b0000, 1'b1);
    cycle();
    for (int c = 0; c < 3; c++) begin
      drive(4'b0110, (c == 2) ? 4'b0100 : 4'b0000, 1'b1);
      #1 chk("t3_r1_blocked", 32'(ready_in[1]), 32'd0);
      cycle();
    end
    drive(4'b0010, 4'b0010, 1'b1);
    #1 chk("t3_r1_granted", 32'(ready_in), 32'b0010);
    cycle();

    // Downstream stall: exactly two beats absorbed.
    do_reset();
    acc0 = dut_acc;
    for (int c = 0; c < 5; c++) begin
      drive(4'b0001, 4'b0001, 1'b0);
      cycle();
    end
    chk("t4_accepted", 32'(dut_acc - acc0), 32'd2);
    for (int c = 0; c < 4; c++) begin
      drive(4'b0001, 4'b0001, 1'b1);
      cycle();
    end

    // Reset in the middle of beat 2 of a 3-beat packet.
    do_reset();
    drive(4'b0001, 4'b0000, 1'b1);
    cycle();
    drive(4'b0001, 4'b0000, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t5_valid_out", 32'(valid_out), 32'd0);
    chk("t5_ready_in", 32'(ready_in), 32'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(4'b1000, 4'b1000, 1'b1);
    cycle();
    drive(4'b0000, 4'b0000, 1'b1);
    cycle();
    chk("t5_fresh_len", 32'(out_log.size()), 32'd1);
    if (out_log.size() > 0) chk("t5_fresh_idx", 32'(out_log[0]), 32'd3);

`ifdef VX_WRR_SCHED_PERF_EN
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(4'b0001, 4'b0001, 1'b0);
      cycle();
    end
    for (int c = 0; c < 3; c++) begin
      drive(4'b0000, 4'b0000, 1'b1);
      cycle();
    end
    chk("perf_stall_cycles", perf_stall_cycles, 32'd3);
    chk("perf_packets", perf_packets, 32'd2);
`endif

    // Random traffic, random back-pressure, occasional weight changes.
    weights_in = $urandom;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      valid_in  = N'($urandom);
      for (int i = 0; i < N; i++) last_in[i] = ($urandom_range(0, 2) == 0);
      data_in   = $urandom;
      ready_out = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) weights_in = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
